// File: rtl/drive_arbiter.sv
// Drive arbiter: fuses distance, pitch and red-pixel inputs into one committed
// drive command, then ramps speed toward it with an emergency-stop override.
module drive_arbiter #(
  parameter int N_DIST    = 2,
  parameter int DIST_W    = 8,
  parameter int TOO_CLOSE = 20,
  parameter int FREQ_W    = 10,
  parameter int THRESH_W  = 5,
  parameter int HYST      = 2,
  parameter int PERSIST   = 5,
  parameter int RAMP_DIV  = 5000000,
  parameter int MAX_SPEED = 7,
  parameter int PIX_W     = 17,
  parameter int RED_MIN   = 2000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_DIST*DIST_W-1:0]   distance,
  input  logic [N_DIST-1:0]          dist_valid,
  input  logic [FREQ_W-1:0]          mic_freq,
  input  logic                       freq_valid,
  input  logic [THRESH_W-1:0]        threshold,
  input  logic [PIX_W-1:0]           red_left,
  input  logic [PIX_W-1:0]           red_right,
  input  logic                       frame_done,
  output logic [2:0]                 direction,
  output logic [2:0]                 speed,
  output logic                       cmd_valid,
  output logic                       obstacle,
  output logic [DIST_W-1:0]          min_distance
);

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_FWD   = 3'd1;
  localparam logic [2:0] DIR_BACK  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [1:0] S_STOP  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_BRAKE = 2'd3;

  localparam int CNT_W = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;
  localparam int RC_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [DIST_W-1:0] NEAR_LIM    = DIST_W'(TOO_CLOSE);
  localparam logic [DIST_W-1:0] RETREAT_LIM = DIST_W'(TOO_CLOSE >> 1);
  localparam logic [11:0]       HYST_C      = 12'(HYST);
  localparam logic [PIX_W:0]    RED_MIN_C   = (PIX_W+1)'(RED_MIN);
  localparam logic [CNT_W-1:0]  PERSIST_C   = CNT_W'(PERSIST);
  localparam logic [RC_W-1:0]   RAMP_LAST   = RC_W'(RAMP_DIV - 1);
  localparam logic [2:0]        CRUISE_FAST = 3'(MAX_SPEED);
  localparam logic [2:0]        CRUISE_SLOW = 3'(MAX_SPEED >> 1);

  // ---------------- distance path ----------------
  logic [DIST_W-1:0] dist_lat [N_DIST];
  logic [DIST_W-1:0] min_comb;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  // NOTE: the latch array is a handful of flops, not a RAM, so resetting it
  // costs nothing and gives a defined "nothing seen yet" distance.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_DIST; k++) dist_lat[k] <= '1;
    end else begin
      for (int k = 0; k < N_DIST; k++)
        if (dist_valid[k]) dist_lat[k] <= distance[k*DIST_W +: DIST_W];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    min_comb = '1;
    for (int k = 0; k < N_DIST; k++)
      if (dist_lat[k] < min_comb) min_comb = dist_lat[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_distance <= '1;
      obstacle     <= 1'b0;
    end else begin
      min_distance <= min_comb;
      obstacle     <= (min_comb < NEAR_LIM);
    end
  end

  // ---------------- pitch hysteresis ----------------
  logic        freq_high, freq_high_nxt;
  logic [11:0] thr_ext, f_ext, hi_lim, lo_lim;

  always_comb begin
    thr_ext       = 12'(threshold);
    f_ext         = 12'(mic_freq);
    hi_lim        = thr_ext + HYST_C;
    lo_lim        = (thr_ext > HYST_C) ? (thr_ext - HYST_C) : 12'd0;
    freq_high_nxt = freq_high;
    if (freq_valid) begin
      if (f_ext > hi_lim)      freq_high_nxt = 1'b1;
      else if (f_ext < lo_lim) freq_high_nxt = 1'b0;
    end
  end

  logic [PIX_W-1:0] red_l, red_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_high <= 1'b0;
      red_l     <= '0;
      red_r     <= '0;
    end else begin
      freq_high <= freq_high_nxt;
      if (frame_done) begin
        red_l <= red_left;
        red_r <= red_right;
      end
    end
  end

  // ---------------- candidate request ----------------
  // The candidate sees the pitch decision of the sample being taken, so the
  // sample that raises freq_high already counts toward persistence.
  logic [2:0]     cand;
  logic           safety;
  logic [PIX_W:0] red_sum;

  always_comb begin
    red_sum = {1'b0, red_l} + {1'b0, red_r};
    safety  = 1'b1;
    cand    = DIR_STOP;
    if (min_distance < RETREAT_LIM) begin
      cand = DIR_BACK;
    end else if (obstacle) begin
      cand = DIR_STOP;
    end else begin
      safety = 1'b0;
      if (!enable || !freq_high_nxt) cand = DIR_STOP;
      else if (red_sum < RED_MIN_C)  cand = DIR_FWD;
      else if (red_l > red_r)        cand = DIR_LEFT;
      else                           cand = DIR_RIGHT;
    end
  end

  // ---------------- persistence filter ----------------
  logic [2:0]       pending, req;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;

  always_comb begin
    pcnt_nxt = CNT_W'(1);
    if (cand == pending)
      pcnt_nxt = (pcnt == PERSIST_C) ? pcnt : pcnt + 1'b1;
  end

  // Safety requests commit at once and restart persistence, so leaving the
  // safety region always needs a full run of fresh samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= DIR_STOP;
      pcnt    <= '0;
      req     <= DIR_STOP;
    end else if (safety) begin
      pending <= cand;
      pcnt    <= '0;
      req     <= cand;
    end else if (freq_valid) begin
      pending <= cand;
      pcnt    <= pcnt_nxt;
      if (pcnt_nxt == PERSIST_C) req <= cand;
    end
  end

  // ---------------- speed ramp FSM ----------------
  logic [1:0]      state;
  logic [RC_W-1:0] ramp_cnt;
  logic            tick, estop;
  logic [2:0]      target;
  logic [5:0]      last_cmd;

  always_comb begin
    tick   = (ramp_cnt == RAMP_LAST);
    estop  = obstacle && (direction == DIR_FWD || direction == DIR_LEFT ||
                          direction == DIR_RIGHT);
    target = CRUISE_SLOW;
    if (req == DIR_STOP)     target = 3'd0;
    else if (req == DIR_FWD) target = CRUISE_FAST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_STOP;
      direction <= DIR_STOP;
      speed     <= 3'd0;
      ramp_cnt  <= '0;
    end else begin
      ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
      if (estop) begin
        state     <= S_STOP;
        direction <= DIR_STOP;
        speed     <= 3'd0;
      end else begin
        case (state)
          S_STOP: begin
            if (req != DIR_STOP) begin
              direction <= req;
              speed     <= 3'd1;
              state     <= S_RAMP;
              ramp_cnt  <= '0;
            end
          end
          S_RAMP: begin
            // A direction change must brake through zero, never ramp sideways.
            if (req != direction || target < speed) begin
              state    <= S_BRAKE;
              ramp_cnt <= '0;
            end else if (speed == target) begin
              state <= S_RUN;
            end else if (tick) begin
              speed <= speed + 3'd1;
            end
          end
          S_RUN: begin
            if (req != direction) begin
              state    <= S_BRAKE;
              ramp_cnt <= '0;
            end
          end
          S_BRAKE: begin
            if (req == direction) begin
              state    <= S_RAMP;
              ramp_cnt <= '0;
            end else if (tick) begin
              if (speed <= 3'd1) begin
                speed     <= 3'd0;
                direction <= DIR_STOP;
                state     <= S_STOP;
              end else begin
                speed <= speed - 3'd1;
              end
            end
          end
          default: state <= S_STOP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cmd  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      last_cmd  <= {direction, speed};
      cmd_valid <= ({direction, speed} != last_cmd);
    end
  end

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with RAMP_DIV=4, PERSIST=3, N_DIST=2;
// expected values are hand-derived cycle counts from each stimulus step.
module tb_drive_arbiter;

  logic        clk = 1'b0;
  logic        reset, enable, freq_valid, frame_done;
  logic [15:0] distance;
  logic [1:0]  dist_valid;
  logic [9:0]  mic_freq;
  logic [4:0]  threshold;
  logic [16:0] red_left, red_right;
  logic [2:0]  direction, speed;
  logic        cmd_valid, obstacle;
  logic [7:0]  min_distance;

  int checks = 0;
  int failures = 0;
  int cmd_pulses = 0;
  int base;

  always #5 clk = ~clk;

  drive_arbiter #(.N_DIST(2), .PERSIST(3), .RAMP_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .distance(distance), .dist_valid(dist_valid),
    .mic_freq(mic_freq), .freq_valid(freq_valid), .threshold(threshold),
    .red_left(red_left), .red_right(red_right), .frame_done(frame_done),
    .direction(direction), .speed(speed), .cmd_valid(cmd_valid),
    .obstacle(obstacle), .min_distance(min_distance)
  );

  always @(negedge clk) if (!reset && cmd_valid) cmd_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic freq_pulses(input logic [9:0] f, input int n);
    mic_freq = f; freq_valid = 1'b1; cyc(n); freq_valid = 1'b0;
  endtask

  task automatic strobe_dist(input logic [7:0] d1, input logic [7:0] d0, input logic [1:0] v);
    distance = {d1, d0}; dist_valid = v; cyc(1); dist_valid = 2'b00;
  endtask

  task automatic new_frame(input logic [16:0] l, input logic [16:0] r);
    red_left = l; red_right = r; frame_done = 1'b1; cyc(1); frame_done = 1'b0;
  endtask

  task automatic wait_dir(input logic [2:0] d, input int budget, input string tag);
    int n = 0;
    while (direction !== d && n < budget) begin cyc(1); n++; end
    check(tag, 32'(direction), 32'(d));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; distance = {8'd100, 8'd100}; dist_valid = 2'b11;
    mic_freq = 10'd13; freq_valid = 1'b1; threshold = 5'd10;
    red_left = '0; red_right = '0; frame_done = 1'b0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("reset_dir", 32'(direction), 0);
      check("reset_speed", 32'(speed), 0);
      check("reset_cmd", 32'(cmd_valid), 0);
    end
    reset = 1'b0; dist_valid = 2'b00; freq_valid = 1'b0;
    cyc(1);
    check("reset_min", 32'(min_distance), 255);
    check("reset_obstacle", 32'(obstacle), 0);

    strobe_dist(8'd100, 8'd100, 2'b11);
    cyc(1);
    check("min_100", 32'(min_distance), 100);

    // exactly threshold+HYST must not raise freq_high
    freq_pulses(10'd12, 3);
    cyc(3);
    check("band_edge_no_set", 32'(direction), 0);

    base = cmd_pulses;
    freq_pulses(10'd13, 3);
    check("fwd_not_yet", 32'(direction), 0);
    cyc(1);
    check("fwd_dir", 32'(direction), 1);
    check("fwd_speed1", 32'(speed), 1);
    check("cmd_lag", 32'(cmd_valid), 0);
    cyc(1);
    check("cmd_pulse", 32'(cmd_valid), 1);
    cyc(1);
    check("cmd_single", 32'(cmd_valid), 0);
    cyc(2);
    check("ramp_s2", 32'(speed), 2);
    for (int s = 3; s <= 7; s++) begin
      cyc(3);
      check("ramp_hold", 32'(speed), 32'(s - 1));
      cyc(1);
      check("ramp_step", 32'(speed), 32'(s));
    end
    cyc(4);
    check("cruise_fwd", 32'(speed), 7);
    check("fwd_pulses", 32'(cmd_pulses - base), 7);

    freq_pulses(10'd11, 1);
    freq_pulses(10'd9, 1);
    freq_pulses(10'd8, 1);
    cyc(4);
    check("hyst_hold_dir", 32'(direction), 1);
    check("hyst_hold_speed", 32'(speed), 7);

    base = cmd_pulses;
    freq_pulses(10'd7, 3);
    cyc(1);
    check("brake_entry", 32'(speed), 7);
    for (int s = 6; s >= 0; s--) begin
      cyc(3);
      check("brake_hold", 32'(speed), 32'(s + 1));
      cyc(1);
      check("brake_step", 32'(speed), 32'(s));
    end
    check("brake_stop_dir", 32'(direction), 0);
    cyc(2);
    check("brake_pulses", 32'(cmd_pulses - base), 7);

    // emergency stop lands on the same edge as a ramp tick
    freq_pulses(10'd13, 3);
    cyc(17);
    check("estop_pre_speed", 32'(speed), 5);
    cyc(1);
    strobe_dist(8'd15, 8'd100, 2'b10);
    cyc(1);
    check("estop_obstacle", 32'(obstacle), 1);
    check("estop_min", 32'(min_distance), 15);
    check("estop_still_5", 32'(speed), 5);
    cyc(1);
    check("estop_dir", 32'(direction), 0);
    check("estop_speed", 32'(speed), 0);
    cyc(3);
    check("estop_stays", 32'({direction, speed}), 0);

    strobe_dist(8'd15, 8'd8, 2'b01);
    cyc(1);
    check("back_min", 32'(min_distance), 8);
    cyc(1);
    check("back_not_yet", 32'(direction), 0);
    cyc(1);
    check("back_dir", 32'(direction), 2);
    check("back_speed1", 32'(speed), 1);
    cyc(8);
    check("back_speed3", 32'(speed), 3);
    cyc(4);
    check("back_cruise", 32'({direction, speed}), 32'({3'd2, 3'd3}));

    strobe_dist(8'd50, 8'd50, 2'b11);
    cyc(1);
    check("clear_obstacle", 32'(obstacle), 0);
    freq_pulses(10'd13, 3);
    check("back_held", 32'({direction, speed}), 32'({3'd2, 3'd3}));
    cyc(1);
    check("back_brake_entry", 32'(speed), 3);
    cyc(4);
    check("back_brake2", 32'(speed), 2);
    cyc(4);
    check("back_brake1", 32'(speed), 1);
    cyc(4);
    check("back_brake0", 32'({direction, speed}), 0);
    cyc(1);
    check("back_to_fwd", 32'({direction, speed}), 32'({3'd1, 3'd1}));
    cyc(24);
    check("fwd2_cruise", 32'(speed), 7);

    new_frame(17'd3000, 17'd1000);
    freq_pulses(10'd13, 3);
    check("left_pending", 32'({direction, speed}), 32'({3'd1, 3'd7}));
    cyc(29);
    check("left_brake_done", 32'({direction, speed}), 0);
    cyc(1);
    check("left_dir", 32'({direction, speed}), 32'({3'd3, 3'd1}));
    cyc(8);
    check("left_speed3", 32'(speed), 3);
    cyc(4);
    check("left_cruise", 32'({direction, speed}), 32'({3'd3, 3'd3}));

    new_frame(17'd2000, 17'd2000);
    freq_pulses(10'd13, 3);
    cyc(13);
    check("right_brake_done", 32'({direction, speed}), 0);
    cyc(1);
    check("right_dir", 32'({direction, speed}), 32'({3'd4, 3'd1}));
    cyc(4);
    check("right_speed2", 32'(speed), 2);

    reset = 1'b1;
    cyc(1);
    check("midreset_cmd", 32'({direction, speed}), 0);
    check("midreset_valid", 32'(cmd_valid), 0);
    check("midreset_min", 32'(min_distance), 255);
    check("midreset_obstacle", 32'(obstacle), 0);
    reset = 1'b0;
    cyc(3);
    check("post_reset_idle", 32'(direction), 0);

    // threshold=0: the clear limit saturates at 0, so freq_high sticks
    threshold = 5'd0;
    freq_pulses(10'd5, 3);
    cyc(1);
    check("thr0_fwd", 32'({direction, speed}), 32'({3'd1, 3'd1}));
    freq_pulses(10'd0, 3);
    cyc(1);
    check("thr0_no_clear", 32'({direction, speed}), 32'({3'd1, 3'd2}));

    enable = 1'b0;
    freq_pulses(10'd5, 3);
    wait_dir(3'd0, 60, "enable_low_stop");
    check("enable_low_speed", 32'(speed), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
